// File: rtl/c2c_link_tester.sv
// Multi-channel chip2chip bring-up engine: lock synchroniser, counting-pattern
// transmitters and per-channel receive checkers with alignment and loss detection.
module c2c_link_tester #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned SYNC_COUNT = 16,
   parameter int unsigned LOSS_COUNT = 4,
   parameter int unsigned ERR_W      = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_pll_lock,
   input  logic                       i_soft_rst,
   input  logic [NUM_CH-1:0]          i_partner_rdy,
   input  logic                       i_tx_en,
   input  logic [NUM_CH-1:0]          i_rx_valid,
   input  logic [NUM_CH*DATA_W-1:0]   i_rx_data,
   output logic [NUM_CH*DATA_W-1:0]   o_tx_data,
   output logic [NUM_CH-1:0]          o_link_rst,
   output logic                       o_rdy_out,
   output logic [NUM_CH-1:0]          o_aligned,
   output logic [NUM_CH*2-1:0]        o_ch_state,
   output logic [NUM_CH*ERR_W-1:0]    o_err_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_CHECK = 2'd2,
      ST_LOST  = 2'd3
   } state_t;

   localparam logic [DATA_W-1:0] LP_ONE       = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [7:0]        LP_SYNC_LAST = 8'(SYNC_COUNT - 1);
   localparam logic [7:0]        LP_LOSS_LAST = 8'(LOSS_COUNT - 1);

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
   endfunction

   logic [2:0] r_lock_sync;
   logic       w_lock_s;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lock_sync <= 3'b000;
      end else begin
         r_lock_sync <= {r_lock_sync[1:0], i_pll_lock};
      end
   end

   assign w_lock_s  = r_lock_sync[2];
   assign o_rdy_out = w_lock_s;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic              w_link_rst;
      logic [DATA_W-1:0] r_tx;
      logic [DATA_W-1:0] w_rx;
      logic              w_match;
      state_t            r_state, w_state_nxt;
      logic [DATA_W-1:0] r_exp, w_exp_nxt;
      logic [7:0]        r_mcnt, w_mcnt_nxt;
      logic [7:0]        r_ecnt, w_ecnt_nxt;
      logic [ERR_W-1:0]  r_err, w_err_nxt;
      logic              r_aligned;

      // Soft reset holds every link in reset regardless of lock or partner state.
      assign w_link_rst = !(w_lock_s & i_partner_rdy[g]) | i_soft_rst;
      assign w_rx       = i_rx_data[g*DATA_W +: DATA_W];
      assign w_match    = (w_rx == r_exp);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_tx <= '0;
         end else if (w_link_rst) begin
            r_tx <= '0;
         end else if (i_tx_en) begin
            r_tx <= r_tx + LP_ONE;
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_exp     <= '0;
            r_mcnt    <= 8'd0;
            r_ecnt    <= 8'd0;
            r_err     <= '0;
            r_aligned <= 1'b0;
         end else begin
            r_state   <= w_state_nxt;
            r_exp     <= w_exp_nxt;
            r_mcnt    <= w_mcnt_nxt;
            r_ecnt    <= w_ecnt_nxt;
            r_err     <= w_err_nxt;
            r_aligned <= (w_state_nxt == ST_CHECK);
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_exp_nxt   = r_exp;
         w_mcnt_nxt  = r_mcnt;
         w_ecnt_nxt  = r_ecnt;
         w_err_nxt   = r_err;
         if (w_link_rst) begin
            w_state_nxt = ST_IDLE;
            w_exp_nxt   = '0;
            w_mcnt_nxt  = 8'd0;
            w_ecnt_nxt  = 8'd0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  w_state_nxt = ST_ALIGN;
                  w_mcnt_nxt  = 8'd0;
                  w_ecnt_nxt  = 8'd0;
               end
               ST_ALIGN: begin
                  if (i_rx_valid[g]) begin
                     // Re-seed from the incoming word so alignment tracks any start value.
                     w_exp_nxt = w_rx + LP_ONE;
                     if (w_match) begin
                        if (r_mcnt == LP_SYNC_LAST) begin
                           w_state_nxt = ST_CHECK;
                           w_mcnt_nxt  = 8'd0;
                        end else begin
                           w_mcnt_nxt = r_mcnt + 8'd1;
                        end
                     end else begin
                        w_mcnt_nxt = 8'd0;
                     end
                  end
               end
               ST_CHECK: begin
                  if (i_rx_valid[g]) begin
                     w_exp_nxt = r_exp + LP_ONE;
                     if (!w_match) begin
                        w_err_nxt  = sat_inc(r_err);
                        w_ecnt_nxt = r_ecnt + 8'd1;
                        if (r_ecnt == LP_LOSS_LAST) begin
                           w_state_nxt = ST_LOST;
                        end
                     end else begin
                        w_ecnt_nxt = 8'd0;
                     end
                  end
               end
               ST_LOST: begin
                  w_state_nxt = ST_ALIGN;
                  w_mcnt_nxt  = 8'd0;
                  w_ecnt_nxt  = 8'd0;
               end
            endcase
         end
         if (i_soft_rst) begin
            w_err_nxt = '0;
         end
      end

      assign o_tx_data[g*DATA_W +: DATA_W] = r_tx;
      assign o_link_rst[g]                 = w_link_rst;
      assign o_aligned[g]                  = r_aligned;
      assign o_ch_state[g*2 +: 2]          = r_state;
      assign o_err_count[g*ERR_W +: ERR_W] = r_err;
   end

endmodule

// File: tb/tb_c2c_link_tester.sv
// Directed and randomized bench for c2c_link_tester with a cycle-level behavioural model.
module tb_c2c_link_tester;
   localparam int NCH = 2;
   localparam int DW  = 8;
   localparam int EW  = 4;
   localparam int SC  = 16;
   localparam int LC  = 4;
   localparam int DMOD   = 1 << DW;
   localparam int ERRMAX = (1 << EW) - 1;

   logic               clk = 1'b0;
   logic               rst_n, pll_lock, soft_rst, tx_en;
   logic [NCH-1:0]     partner_rdy, rx_valid;
   logic [NCH*DW-1:0]  rx_data;
   logic [NCH*DW-1:0]  tx_data;
   logic [NCH-1:0]     link_rst, aligned;
   logic               rdy_out;
   logic [NCH*2-1:0]   ch_state;
   logic [NCH*EW-1:0]  err_count;

   int checks = 0;
   int failures = 0;

   int m_tx[NCH], m_st[NCH], m_exp[NCH], m_mc[NCH], m_ec[NCH], m_err[NCH];
   bit m_s[3];
   int corr[NCH];

   always #5 clk = ~clk;

   c2c_link_tester #(.NUM_CH(NCH), .DATA_W(DW), .SYNC_COUNT(SC), .LOSS_COUNT(LC), .ERR_W(EW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pll_lock(pll_lock), .i_soft_rst(soft_rst),
      .i_partner_rdy(partner_rdy), .i_tx_en(tx_en), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
      .o_tx_data(tx_data), .o_link_rst(link_rst), .o_rdy_out(rdy_out), .o_aligned(aligned),
      .o_ch_state(ch_state), .o_err_count(err_count));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit lr(int c);
      return !(m_s[2] && partner_rdy[c]) || soft_rst;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_tx[c] = 0; m_st[c] = 0; m_exp[c] = 0; m_mc[c] = 0; m_ec[c] = 0; m_err[c] = 0;
      end
      for (int k = 0; k < 3; k++) m_s[k] = 1'b0;
   endtask

   // One rising edge of the reference: pattern source, then the checker rules per word.
   task automatic model_step();
      int rxw;
      bit lrc;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int c = 0; c < NCH; c++) begin
         lrc = lr(c);
         rxw = int'(rx_data[c*DW +: DW]);
         if (lrc) m_tx[c] = 0;
         else if (tx_en) m_tx[c] = (m_tx[c] + 1) % DMOD;
         if (lrc) begin
            m_st[c] = 0; m_exp[c] = 0; m_mc[c] = 0; m_ec[c] = 0;
         end else if (m_st[c] == 0 || m_st[c] == 3) begin
            m_st[c] = 1; m_mc[c] = 0; m_ec[c] = 0;
         end else if (rx_valid[c] && m_st[c] == 1) begin
            if (rxw == m_exp[c]) begin
               m_mc[c]++;
               if (m_mc[c] == SC) begin
                  m_st[c] = 2; m_mc[c] = 0;
               end
            end else begin
               m_mc[c] = 0;
            end
            m_exp[c] = (rxw + 1) % DMOD;
         end else if (rx_valid[c] && m_st[c] == 2) begin
            if (rxw != m_exp[c]) begin
               if (m_err[c] < ERRMAX) m_err[c]++;
               m_ec[c]++;
               if (m_ec[c] == LC) m_st[c] = 3;
            end else begin
               m_ec[c] = 0;
            end
            m_exp[c] = (m_exp[c] + 1) % DMOD;
         end
         if (soft_rst) m_err[c] = 0;
      end
      m_s[2] = m_s[1];
      m_s[1] = m_s[0];
      m_s[0] = pll_lock;
   endtask

   task automatic check_all();
      chk("rdy_out", rdy_out, m_s[2]);
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("tx_data[%0d]", c), tx_data[c*DW +: DW], m_tx[c]);
         chk($sformatf("ch_state[%0d]", c), ch_state[c*2 +: 2], m_st[c]);
         chk($sformatf("aligned[%0d]", c), aligned[c], m_st[c] == 2);
         chk($sformatf("err_count[%0d]", c), err_count[c*EW +: EW], m_err[c]);
         chk($sformatf("link_rst[%0d]", c), link_rst[c], lr(c));
      end
   endtask

   task automatic cyc();
      for (int c = 0; c < NCH; c++) rx_data[c*DW +: DW] = DW'(m_tx[c] ^ corr[c]);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int found;
      rst_n = 1'b0; pll_lock = 1'b0; soft_rst = 1'b0; tx_en = 1'b1;
      partner_rdy = 2'b11; rx_valid = 2'b00; rx_data = '0;
      corr[0] = 0; corr[1] = 0;
      model_reset();
      #1;
      chk("reset_tx", tx_data, 0);
      chk("reset_link_rst", link_rst, 2'b11);
      chk("reset_err", err_count, 0);
      for (int i = 0; i < 5; i++) cyc();
      rst_n = 1'b1;

      // Lock sequencing and counting pattern
      pll_lock = 1'b1; rx_valid = 2'b11;
      cyc(); cyc();
      chk("rdy_before_3", rdy_out, 1'b0);
      chk("lrst_before_3", link_rst, 2'b11);
      cyc();
      chk("rdy_at_3", rdy_out, 1'b1);
      chk("lrst_at_3", link_rst, 2'b00);
      chk("tx_count0", tx_data[DW-1:0], 0);
      cyc();
      chk("tx_count1", tx_data[DW-1:0], 1);
      chk("state_align", ch_state, 4'b0101);
      cyc();
      chk("tx_count2", tx_data[DW-1:0], 2);
      for (int i = 0; i < 15; i++) cyc();
      chk("not_aligned_15", aligned, 2'b00);
      cyc();
      chk("aligned_16th", aligned, 2'b11);

      // Loopback with random joint pauses
      for (int i = 0; i < 1000; i++) begin
         bit p;
         p = ($urandom_range(0, 7) == 0);
         tx_en = !p;
         rx_valid = p ? 2'b00 : 2'b11;
         cyc();
      end
      tx_en = 1'b1; rx_valid = 2'b11;
      cyc();
      chk("loop_err_zero", err_count, 0);
      chk("loop_aligned", aligned, 2'b11);

      // Single bit-0 error on ch0
      corr[0] = 1; cyc(); corr[0] = 0;
      chk("single_err_ch0", err_count[EW-1:0], 1);
      chk("single_err_ch1", err_count[2*EW-1:EW], 0);
      cyc(); cyc();
      chk("single_aligned", aligned, 2'b11);

      // Four consecutive errors on ch1
      for (int i = 0; i < 4; i++) begin
         corr[1] = $urandom_range(1, DMOD - 1);
         cyc();
      end
      corr[1] = 0;
      chk("loss_state", ch_state[3:2], 2'd3);
      chk("loss_aligned", aligned[1], 1'b0);
      chk("loss_err", err_count[2*EW-1:EW], 4);
      cyc();
      chk("loss_to_align", ch_state[3:2], 2'd1);
      for (int i = 0; i < 20; i++) cyc();
      chk("realigned", aligned, 2'b11);
      chk("realign_err", err_count[2*EW-1:EW], 4);

      // Saturation: groups of three errors then one clean word on ch0
      for (int g = 0; g < 7; g++) begin
         for (int i = 0; i < 3; i++) begin
            corr[0] = $urandom_range(1, DMOD - 1);
            cyc();
         end
         corr[0] = 0;
         cyc();
      end
      chk("sat_err", err_count[EW-1:0], ERRMAX);
      chk("sat_aligned", aligned[0], 1'b1);

      // Pattern wrap
      found = 0;
      for (int i = 0; i < 300 && found == 0; i++) begin
         if (m_tx[0] == DMOD - 1) found = 1;
         else cyc();
      end
      chk("wrap_found", found, 1);
      cyc();
      chk("wrap_tx0", tx_data[DW-1:0], 0);
      chk("wrap_aligned", aligned, 2'b11);
      chk("wrap_err1", err_count[2*EW-1:EW], 4);

      // Partner drop on ch0
      partner_rdy = 2'b10;
      #1;
      chk("drop_lrst", link_rst, 2'b01);
      cyc();
      partner_rdy = 2'b11;
      chk("drop_idle", ch_state[1:0], 2'd0);
      chk("drop_tx0", tx_data[DW-1:0], 0);
      chk("drop_aligned", aligned, 2'b10);
      chk("drop_err_kept", err_count[EW-1:0], ERRMAX);
      for (int i = 0; i < 20; i++) cyc();
      chk("drop_realigned", aligned, 2'b11);

      // Soft reset pulse
      soft_rst = 1'b1;
      #1;
      chk("soft_lrst", link_rst, 2'b11);
      cyc();
      soft_rst = 1'b0;
      chk("soft_err", err_count, 0);
      chk("soft_state", ch_state, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         tx_en = 1'($urandom_range(0, 1));
         rx_valid = NCH'($urandom_range(0, 3));
         for (int c = 0; c < NCH; c++)
            corr[c] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, DMOD - 1) : 0;
         partner_rdy = ($urandom_range(0, 49) == 0) ? NCH'($urandom_range(0, 3)) : 2'b11;
         soft_rst = ($urandom_range(0, 199) == 0);
         cyc();
      end
      corr[0] = 0; corr[1] = 0; soft_rst = 1'b0; partner_rdy = 2'b11;

      // Asynchronous reset mid-run
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      cyc(); cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
